// File: rtl/div_pkg.sv
// Shared types and constants for the iterative radix-2 DIV/DIVU unit.
// FSM state encodings, handshake levels and default widths live here.
package div_pkg;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_CNT_W  = 6;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    localparam logic [DIV_DATA_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/div_if.sv
// Execute-stage <-> divider bus: operands and start/annul in, {hi,lo} result,
// ready and busy out. The execute stage is the master.
interface div_if #(
    parameter int DATA_W = 32
);
    logic                  signed_div_i;
    logic [DATA_W-1:0]     div_opdata1_i;
    logic [DATA_W-1:0]     div_opdata2_i;
    logic                  div_start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   div_result_o;
    logic                  div_ready_o;
    logic                  div_busy_o;

    modport master (
        output signed_div_i,
        output div_opdata1_i,
        output div_opdata2_i,
        output div_start_i,
        output annul_i,
        input  div_result_o,
        input  div_ready_o,
        input  div_busy_o
    );

    modport slave (
        input  signed_div_i,
        input  div_opdata1_i,
        input  div_opdata2_i,
        input  div_start_i,
        input  annul_i,
        output div_result_o,
        output div_ready_o,
        output div_busy_o
    );
endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract step: brings in the next dividend bit and
// subtracts the divisor when the shifted remainder is large enough.
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] partial_rem,
    input  logic              dividend_bit,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_next,
    output logic              quot_bit
);
    logic [DATA_W:0] shifted;
    logic [DATA_W:0] trial;

    // partial_rem < divisor always holds, so DATA_W+1 bits never overflow
    assign shifted  = {partial_rem, dividend_bit};
    assign trial    = shifted - {1'b0, divisor};
    assign quot_bit = ~trial[DATA_W];
    assign rem_next = quot_bit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
endmodule

// File: rtl/div.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU, feeding {hi, lo}.
// Works on magnitudes and fixes the signs on the final iteration.
module div
    import div_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int CNT_W  = DIV_CNT_W
) (
    input  logic cpu_clk_50M,
    input  logic cpu_rst_n,
    div_if.slave bus
);
    div_state_e           state_reg,    state_next;
    logic [CNT_W-1:0]     counter_reg,  counter_next;
    logic [DATA_W-1:0]    dividend_reg, dividend_next;
    logic [DATA_W-1:0]    divisor_reg,  divisor_next;
    logic [DATA_W-1:0]    rem_reg,      rem_next;
    logic [DATA_W-1:0]    quot_reg,     quot_next;
    logic                 quot_neg_reg, quot_neg_next;
    logic                 rem_neg_reg,  rem_neg_next;
    logic [2*DATA_W-1:0]  result_reg,   result_next;
    logic                 ready_reg,    ready_next;

    logic [DATA_W-1:0]    step_rem;
    logic                 step_quot_bit;
    logic [DATA_W-1:0]    final_quot;
    logic [DATA_W-1:0]    fixed_quot;
    logic [DATA_W-1:0]    fixed_rem;
    logic                 op1_neg;
    logic                 op2_neg;

    div_step #(.DATA_W(DATA_W)) u_step (
        .partial_rem  (rem_reg),
        .dividend_bit (dividend_reg[DATA_W-1]),
        .divisor      (divisor_reg),
        .rem_next     (step_rem),
        .quot_bit     (step_quot_bit)
    );

    assign op1_neg    = bus.signed_div_i & bus.div_opdata1_i[DATA_W-1];
    assign op2_neg    = bus.signed_div_i & bus.div_opdata2_i[DATA_W-1];
    assign final_quot = {quot_reg[DATA_W-2:0], step_quot_bit};
    assign fixed_quot = quot_neg_reg ? (~final_quot + 1'b1) : final_quot;
    assign fixed_rem  = rem_neg_reg  ? (~step_rem + 1'b1)   : step_rem;

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_reg    <= DIV_FREE;
            counter_reg  <= '0;
            dividend_reg <= '0;
            divisor_reg  <= '0;
            rem_reg      <= '0;
            quot_reg     <= '0;
            quot_neg_reg <= 1'b0;
            rem_neg_reg  <= 1'b0;
            result_reg   <= '0;
            ready_reg    <= DIV_RESULT_NOT_READY;
        end else begin
            state_reg    <= state_next;
            counter_reg  <= counter_next;
            dividend_reg <= dividend_next;
            divisor_reg  <= divisor_next;
            rem_reg      <= rem_next;
            quot_reg     <= quot_next;
            quot_neg_reg <= quot_neg_next;
            rem_neg_reg  <= rem_neg_next;
            result_reg   <= result_next;
            ready_reg    <= ready_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        counter_next  = counter_reg;
        dividend_next = dividend_reg;
        divisor_next  = divisor_reg;
        rem_next      = rem_reg;
        quot_next     = quot_reg;
        quot_neg_next = quot_neg_reg;
        rem_neg_next  = rem_neg_reg;
        result_next   = result_reg;
        ready_next    = ready_reg;

        unique case (state_reg)
            DIV_FREE: begin
                ready_next  = DIV_RESULT_NOT_READY;
                result_next = '0;
                if (bus.div_start_i == DIV_START && !bus.annul_i) begin
                    if (bus.div_opdata2_i == '0) begin
                        state_next = DIV_BY_ZERO;
                    end else begin
                        // two's-complement magnitude; 0x80000000 maps to itself, which is correct unsigned
                        dividend_next = op1_neg ? (~bus.div_opdata1_i + 1'b1) : bus.div_opdata1_i;
                        divisor_next  = op2_neg ? (~bus.div_opdata2_i + 1'b1) : bus.div_opdata2_i;
                        quot_neg_next = op1_neg ^ op2_neg;
                        rem_neg_next  = op1_neg;
                        rem_next      = '0;
                        quot_next     = '0;
                        counter_next  = '0;
                        state_next    = DIV_ON;
                    end
                end
            end
            DIV_BY_ZERO: begin
                // architecturally unpredictable; zero is as good as anything
                result_next = '0;
                state_next  = DIV_END;
            end
            DIV_ON: begin
                if (bus.annul_i) begin
                    ready_next  = DIV_RESULT_NOT_READY;
                    result_next = '0;
                    state_next  = DIV_FREE;
                end else begin
                    rem_next      = step_rem;
                    quot_next     = final_quot;
                    dividend_next = {dividend_reg[DATA_W-2:0], 1'b0};
                    counter_next  = counter_reg + CNT_W'(1);
                    if (counter_reg == CNT_W'(DATA_W - 1)) begin
                        result_next = {fixed_rem, fixed_quot};
                        ready_next  = DIV_RESULT_READY;
                        state_next  = DIV_END;
                    end
                end
            end
            DIV_END: begin
                // divide-by-zero arrives here not yet ready; raise it now
                ready_next = DIV_RESULT_READY;
                if (bus.annul_i || bus.div_start_i == DIV_STOP) begin
                    ready_next  = DIV_RESULT_NOT_READY;
                    result_next = '0;
                    state_next  = DIV_FREE;
                end
            end
            default: begin
                state_next = DIV_FREE;
            end
        endcase
    end

    assign bus.div_result_o = result_reg;
    assign bus.div_ready_o  = ready_reg;
    assign bus.div_busy_o   = (state_reg == DIV_BY_ZERO) || (state_reg == DIV_ON);

endmodule

// File: tb/tb_div.sv
// Directed test of the iterative divider: latency, busy window, signed and
// unsigned results, divide-by-zero, annul, async reset and END hold.
module tb_div;
    logic cpu_clk_50M = 1'b0;
    logic cpu_rst_n   = 1'b0;

    always #10 cpu_clk_50M = ~cpu_clk_50M;

    div_if #(.DATA_W(32)) bus ();

    div dut (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst_n   (cpu_rst_n),
        .bus         (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic drive_idle();
        bus.signed_div_i  = 1'b0;
        bus.div_opdata1_i = '0;
        bus.div_opdata2_i = '0;
        bus.div_start_i   = 1'b0;
        bus.annul_i       = 1'b0;
    endtask

    // Drive a request at a negedge; returns just after the edge that samples it.
    task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge cpu_clk_50M);
        bus.signed_div_i  = sgn;
        bus.div_opdata1_i = a;
        bus.div_opdata2_i = b;
        bus.div_start_i   = 1'b1;
        bus.annul_i       = 1'b0;
        @(posedge cpu_clk_50M);
    endtask

    // cycles = edges after the sampling edge until ready is seen; -1 on timeout.
    task automatic wait_ready(output int cycles, output int busy_cnt);
        cycles   = 0;
        busy_cnt = 0;
        while (1) begin
            @(negedge cpu_clk_50M);
            if (bus.div_ready_o === 1'b1) break;
            if (bus.div_busy_o === 1'b1) busy_cnt++;
            if (cycles >= 100) begin
                cycles = -1;
                break;
            end
            @(posedge cpu_clk_50M);
            cycles++;
        end
    endtask

    task automatic release_op();
        @(negedge cpu_clk_50M);
        bus.div_start_i = 1'b0;
        bus.annul_i     = 1'b0;
        @(posedge cpu_clk_50M);
    endtask

    task automatic test_reset();
        drive_idle();
        cpu_rst_n = 1'b0;
        repeat (3) @(posedge cpu_clk_50M);
        @(negedge cpu_clk_50M);
        checks++; if (bus.div_result_o !== 64'h0) begin errors++; $display("FAIL reset_result got %h exp %h", bus.div_result_o, 64'h0); end
        checks++; if (bus.div_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", bus.div_ready_o); end
        checks++; if (bus.div_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.div_busy_o); end
        cpu_rst_n = 1'b1;
        @(negedge cpu_clk_50M);
        checks++; if (bus.div_ready_o !== 1'b0 || bus.div_busy_o !== 1'b0) begin errors++; $display("FAIL idle_after_reset got ready=%b busy=%b exp 0 0", bus.div_ready_o, bus.div_busy_o); end
    endtask

    task automatic test_unsigned();
        int cyc, bsy;
        launch(1'b0, 32'd100, 32'd7);
        wait_ready(cyc, bsy);
        $display("DIVU 100/7 -> %h after %0d cycles busy %0d", bus.div_result_o, cyc, bsy);
        checks++; if (cyc !== 32) begin errors++; $display("FAIL divu_latency got %0d exp 32", cyc); end
        checks++; if (bsy !== 32) begin errors++; $display("FAIL divu_busy_cycles got %0d exp 32", bsy); end
        checks++; if (bus.div_result_o !== 64'h00000002_0000000E) begin errors++; $display("FAIL divu_result got %h exp %h", bus.div_result_o, 64'h00000002_0000000E); end
        release_op();
        @(negedge cpu_clk_50M);
        checks++; if (bus.div_ready_o !== 1'b0 || bus.div_result_o !== 64'h0) begin errors++; $display("FAIL divu_clear got ready=%b result=%h exp 0 0", bus.div_ready_o, bus.div_result_o); end
    endtask

    task automatic test_signed();
        logic [31:0] a_tab [3] = '{32'hFFFFFFF9, 32'h00000007, 32'h80000000};
        logic [31:0] b_tab [3] = '{32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFFF};
        logic [63:0] r_tab [3] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD, 64'h00000000_80000000};
        int cyc, bsy;
        for (int i = 0; i < 3; i++) begin
            launch(1'b1, a_tab[i], b_tab[i]);
            wait_ready(cyc, bsy);
            $display("DIV %h/%h -> %h after %0d cycles", a_tab[i], b_tab[i], bus.div_result_o, cyc);
            checks++; if (cyc !== 32) begin errors++; $display("FAIL div_latency_%0d got %0d exp 32", i, cyc); end
            checks++; if (bus.div_result_o !== r_tab[i]) begin errors++; $display("FAIL div_result_%0d got %h exp %h", i, bus.div_result_o, r_tab[i]); end
            release_op();
        end
    endtask

    task automatic test_div_zero();
        int cyc, bsy;
        launch(1'b0, 32'h12345678, 32'h0);
        wait_ready(cyc, bsy);
        $display("DIVU 12345678/0 -> %h after %0d cycles busy %0d", bus.div_result_o, cyc, bsy);
        checks++; if (cyc !== 2) begin errors++; $display("FAIL divzero_latency got %0d exp 2", cyc); end
        checks++; if (bsy !== 1) begin errors++; $display("FAIL divzero_busy got %0d exp 1", bsy); end
        checks++; if (bus.div_result_o !== 64'h0) begin errors++; $display("FAIL divzero_result got %h exp %h", bus.div_result_o, 64'h0); end
        release_op();
    endtask

    task automatic test_annul();
        int cyc, bsy, seen;
        launch(1'b0, 32'd1000, 32'd3);
        repeat (10) @(posedge cpu_clk_50M);
        @(negedge cpu_clk_50M);
        bus.annul_i     = 1'b1;
        bus.div_start_i = 1'b0;
        @(posedge cpu_clk_50M);
        @(negedge cpu_clk_50M);
        bus.annul_i = 1'b0;
        $display("annul at iteration 10 -> busy %b ready %b", bus.div_busy_o, bus.div_ready_o);
        checks++; if (bus.div_busy_o !== 1'b0) begin errors++; $display("FAIL annul_busy got %b exp 0", bus.div_busy_o); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge cpu_clk_50M);
            if (bus.div_ready_o !== 1'b0) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL annul_ready_seen got %0d exp 0", seen); end
        launch(1'b0, 32'hFFFFFFFF, 32'h10);
        wait_ready(cyc, bsy);
        $display("DIVU ffffffff/10 -> %h after %0d cycles", bus.div_result_o, cyc);
        checks++; if (cyc !== 32) begin errors++; $display("FAIL post_annul_latency got %0d exp 32", cyc); end
        checks++; if (bus.div_result_o !== 64'h0000000F_0FFFFFFF) begin errors++; $display("FAIL post_annul_result got %h exp %h", bus.div_result_o, 64'h0000000F_0FFFFFFF); end
        release_op();
    endtask

    task automatic test_async_reset();
        int cyc, bsy;
        launch(1'b1, 32'hFFFFFFF9, 32'h2);
        repeat (5) @(posedge cpu_clk_50M);
        @(negedge cpu_clk_50M);
        checks++; if (bus.div_busy_o !== 1'b1) begin errors++; $display("FAIL pre_reset_busy got %b exp 1", bus.div_busy_o); end
        #3 cpu_rst_n = 1'b0;
        #1;
        $display("async reset mid-ON -> busy %b ready %b result %h", bus.div_busy_o, bus.div_ready_o, bus.div_result_o);
        checks++; if (bus.div_busy_o !== 1'b0) begin errors++; $display("FAIL areset_on_busy got %b exp 0", bus.div_busy_o); end
        checks++; if (bus.div_ready_o !== 1'b0 || bus.div_result_o !== 64'h0) begin errors++; $display("FAIL areset_on_outputs got ready=%b result=%h exp 0 0", bus.div_ready_o, bus.div_result_o); end
        bus.div_start_i = 1'b0;
        @(negedge cpu_clk_50M);
        cpu_rst_n = 1'b1;
        // reset while a result is being presented
        launch(1'b0, 32'd100, 32'd7);
        wait_ready(cyc, bsy);
        #3 cpu_rst_n = 1'b0;
        #1;
        $display("async reset in END -> ready %b result %h", bus.div_ready_o, bus.div_result_o);
        checks++; if (bus.div_ready_o !== 1'b0 || bus.div_result_o !== 64'h0) begin errors++; $display("FAIL areset_end_outputs got ready=%b result=%h exp 0 0", bus.div_ready_o, bus.div_result_o); end
        bus.div_start_i = 1'b0;
        @(negedge cpu_clk_50M);
        cpu_rst_n = 1'b1;
        launch(1'b1, 32'h00000007, 32'hFFFFFFFE);
        wait_ready(cyc, bsy);
        $display("DIV 7/-2 after reset -> %h after %0d cycles", bus.div_result_o, cyc);
        checks++; if (cyc !== 32 || bus.div_result_o !== 64'h00000001_FFFFFFFD) begin errors++; $display("FAIL post_reset_op got cyc=%0d result=%h exp 32 %h", cyc, bus.div_result_o, 64'h00000001_FFFFFFFD); end
        release_op();
    endtask

    task automatic test_hold_end();
        int cyc, bsy;
        launch(1'b0, 32'd100, 32'd7);
        wait_ready(cyc, bsy);
        for (int i = 0; i < 5; i++) begin
            @(posedge cpu_clk_50M);
            @(negedge cpu_clk_50M);
            $display("END hold %0d -> ready %b result %h", i, bus.div_ready_o, bus.div_result_o);
            checks++; if (bus.div_ready_o !== 1'b1) begin errors++; $display("FAIL hold_ready_%0d got %b exp 1", i, bus.div_ready_o); end
            checks++; if (bus.div_result_o !== 64'h00000002_0000000E) begin errors++; $display("FAIL hold_result_%0d got %h exp %h", i, bus.div_result_o, 64'h00000002_0000000E); end
        end
        bus.div_start_i = 1'b0;
        @(posedge cpu_clk_50M);
        @(negedge cpu_clk_50M);
        checks++; if (bus.div_ready_o !== 1'b0 || bus.div_result_o !== 64'h0) begin errors++; $display("FAIL hold_release got ready=%b result=%h exp 0 0", bus.div_ready_o, bus.div_result_o); end
    endtask

    task automatic test_back_to_back();
        int cyc, bsy;
        launch(1'b0, 32'd1000, 32'd3);
        // operands wiggled mid-operation must not disturb the result
        repeat (4) @(posedge cpu_clk_50M);
        @(negedge cpu_clk_50M);
        bus.div_opdata1_i = 32'hDEADBEEF;
        bus.div_opdata2_i = 32'h0;
        bus.signed_div_i  = 1'b1;
        wait_ready(cyc, bsy);
        $display("DIVU 1000/3 -> %h after %0d cycles", bus.div_result_o, cyc);
        checks++; if (bus.div_result_o !== 64'h00000001_0000014D) begin errors++; $display("FAIL b2b_first got %h exp %h", bus.div_result_o, 64'h00000001_0000014D); end
        release_op();
        launch(1'b1, 32'hFFFFFF9C, 32'h00000007);
        wait_ready(cyc, bsy);
        $display("DIV -100/7 -> %h after %0d cycles", bus.div_result_o, cyc);
        checks++; if (cyc !== 32 || bus.div_result_o !== 64'hFFFFFFFE_FFFFFFF2) begin errors++; $display("FAIL b2b_second got cyc=%0d result=%h exp 32 %h", cyc, bus.div_result_o, 64'hFFFFFFFE_FFFFFFF2); end
        release_op();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_annul();
        test_async_reset();
        test_hold_end();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/div.md
Name: div

Overview:
- Multi-cycle iterative radix-2 (restoring) divider for MIPS DIV/DIVU.
- Sits in the execute stage, directly upstream of the HI/LO register file.
- Produces the 64-bit {remainder, quotient} word that is written into {hi, lo}.
- Drives a busy signal so the pipeline stalls while an operation is in flight.

Parameters:
- DATA_W, 32, operand width; equals `REG_BUS width; result width is 2*DATA_W (`DOUBLE_REG_BUS).
- CNT_W, 6, iteration counter width; must hold the value DATA_W.

Ports:
- cpu_clk_50M  in  1  system clock; all state updates on its rising edge.
- cpu_rst_n  in  1  asynchronous, active-low reset.
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU (unsigned); sampled with start.
- div_opdata1_i  in  DATA_W  dividend.
- div_opdata2_i  in  DATA_W  divisor.
- div_start_i  in  1  request; held high by the execute stage until the result is consumed.
- annul_i  in  1  cancel the in-flight operation (branch/exception flush).
- div_result_o  out  2*DATA_W  registered; [63:32] = remainder (HI), [31:0] = quotient (LO).
- div_ready_o  out  1  registered; div_result_o is valid while this is high.
- div_busy_o  out  1  combinational; 1 in DIVZERO or ON states (pipeline stall request).

Behaviour:
- Reset (async, cpu_rst_n=0):
  - state=IDLE, counter=0.
  - div_result_o=0, div_ready_o=0, div_busy_o=0.
  - Reset takes effect immediately, including mid-operation.
- States: IDLE, DIVZERO, ON, END.
- IDLE:
  - div_ready_o=0, div_result_o=0.
  - On an edge with div_start_i=1 and annul_i=0: if divisor==0 go to DIVZERO. Otherwise capture |dividend|, |divisor| (two's-complement abs only when signed_div_i=1), capture the sign flags, set counter=0, go to ON.
  - If div_start_i=1 and annul_i=1, stay in IDLE.
- DIVZERO: next edge → END with result 0 (architecturally UNPREDICTABLE; fixed to 0 here).
- ON, one shift-subtract step per cycle:
  - Form the trial difference {partial_rem[DATA_W-1:0], next dividend bit} − divisor (DATA_W+1 bits).
  - If non-negative: keep the difference and shift in quotient bit 1. Otherwise shift in 0.
  - counter increments each cycle.
  - On the 32nd step (counter==DATA_W-1) the edge also performs sign correction:
    - quotient is negated if signed_div_i && sign(op1)!=sign(op2);
    - remainder is negated if signed_div_i && op1 negative.
  - That same edge registers div_result_o, sets div_ready_o=1 and goes to END.
  - annul_i=1 on any ON edge → IDLE; ready is never raised.
- END:
  - div_ready_o and div_result_o are held while div_start_i=1.
  - div_start_i=0 → IDLE at the next edge, clearing ready and result.
  - annul_i=1 → IDLE.
- Latency: start sampled at edge N; div_ready_o is high from edge N+32 (32 cycles). Divide-by-zero: ready from edge N+2.
- Overflow (signed −2^31 / −1): quotient = 0x80000000 (wraps), remainder = 0. No trap.
- Operand changes while in ON or END are ignored; operands are captured only in IDLE.
- A new start is accepted only from IDLE. Back-to-back operations therefore need one IDLE cycle.

Decomposition:
- Shared defines file (defines.v):
  - state encodings DIV_FREE/DIV_BY_ZERO/DIV_ON/DIV_END (2-bit);
  - DIV_START/DIV_STOP, DIV_RESULT_READY/NOT_READY.
  - Reuse existing `REG_BUS, `DOUBLE_REG_BUS, `ZERO_WORD, `RST_ENABLE.
- One natural combinational sub-module: div_step. It takes the partial remainder, the next dividend bit and the divisor, and returns the new partial remainder and the quotient bit. The FSM, counter and sign logic stay in div.

Test Plan:
- Unsigned 100/7: start held, signed=0 → ready rises 32 cycles after start sample; result=0x00000002_0000000E; busy high for exactly those cycles.
- Signed −7/2 (0xFFFFFFF9 / 0x00000002) → result=0xFFFFFFFF_FFFFFFFD. Signed 7/−2 → 0x00000001_FFFFFFFD.
- Divisor 0, dividend 0x12345678 → ready 2 cycles after start; result=0. Signed 0x80000000 / 0xFFFFFFFF → result=0x00000000_80000000.
- annul_i pulsed at iteration 10 → state IDLE next edge, ready never asserted. A following 0xFFFFFFFF/0x10 unsigned op returns 0x0000000F_0FFFFFFF.
- cpu_rst_n driven low asynchronously mid-ON (between clock edges) → result/ready/busy are 0 immediately. Operation resumes cleanly after release.
- Start held 5 cycles in END → result stable and ready=1 throughout. Start drops → ready=0 and result=0 after the next edge.
